mmult_seq: RTL and testbench
============================

Name: mmult_seq

Overview:
- Parametrised sequential N×N matrix multiplier: C = A·B, or C = C + A·B in accumulate mode.
- Generalises the fixed 3×3 / 8-bit multiplier in dimension, element width and signedness.
- Adds operand capture, a start/busy/valid handshake and an accumulate mode.
- Sits in the lab datapath between the operand source (switches or registers) and the display/compare logic.
- Computes one row of C per clock cycle.

Parameters:
- N, 3, matrix dimension (N ≥ 2).
- W, 8, operand element width in bits.
- SIGNED, 0, 0 = unsigned operands and result; 1 = two's-complement operands and result.
- CW, 2*W+$clog2(N), result element width (18 for the defaults); not intended to be overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a multiply; sampled on the rising edge of clk.
- acc_en  input  1  sampled together with start; 1 = accumulate into the existing C, 0 = overwrite C.
- A_mat  input  N*N*W  operand A, declared [0:N*N*W-1], row-major; element (r,c) occupies bits [(r*N+c)*W +: W].
- B_mat  input  N*N*W  operand B, same packing as A_mat.
- busy  output  1  high while rows are being computed.
- valid  output  1  high when C_mat holds a complete result.
- C_mat  output  N*N*CW  result, declared [0:N*N*CW-1], row-major; element (r,c) occupies bits [(r*N+c)*CW +: CW].

Behaviour:
- Reset: asynchronous on reset_n low, regardless of clk.
  - FSM returns to IDLE; row counter = 0.
  - busy = 0, valid = 0, C_mat = 0, operand registers = 0.
  - Reset mid-calculation aborts the operation; no partial result is signalled.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 → CALC.
  - CALC: row counter r counts 0..N-1; at r = N-1 → DONE.
  - DONE: start=1 → CALC; otherwise stay in DONE.
- Accepted start (state IDLE or DONE, start=1), at that edge:
  - A_mat and B_mat are latched into internal registers; inputs may change freely afterwards.
  - acc_en is latched for the whole operation.
  - busy ← 1, valid ← 0, r ← 0.
  - If acc_en = 0, C_mat ← 0; if acc_en = 1, C_mat is kept.
- CALC, each edge:
  - Row r of C is written: C[r][j] ← (acc ? C[r][j] : 0) + Σk A[r][k]·B[k][j], for j = 0..N-1.
  - Uses N*N parallel W×W multipliers and per-column adder trees.
  - r increments by 1.
- Completion, on the edge that writes row N-1:
  - busy ← 0, valid ← 1, state → DONE.
- Latency: if start is accepted at edge E0, valid is first high after edge EN, i.e. N cycles later (3 cycles for the defaults). Throughput is one result per N+1 cycles.
- valid and C_mat hold in DONE until the next accepted start or reset.
- start while in CALC is ignored: no restart, no operand re-capture, acc_en not re-sampled.
- Arithmetic:
  - Products are W×W → 2W bits, sign- or zero-extended to CW according to SIGNED.
  - Sums, including the accumulation, wrap modulo 2^CW with no saturation and no overflow flag.
  - CW bits are exact for a single multiply; accumulation can wrap.
- During CALC, rows r..N-1 of C_mat show either 0 (overwrite mode) or the old contents (accumulate mode). Consumers must qualify C_mat with valid.

Test Plan:
- Defaults (N=3, W=8, SIGNED=0): A = [1..9] row-major, B = identity, start, acc_en=0 → valid rises exactly 3 cycles after the start edge; C_mat = [1..9]; busy high for exactly 3 cycles.
- Max values: A and B all 255 → every C element = 195075 (0x2FA03); then start again with acc_en=1 and the same operands → every element = 390150 mod 2^18 = 128006.
- Operand capture and ignored start: change A_mat/B_mat and pulse start during the CALC cycles after a start with A = [1..9], B = identity → result still [1..9]; valid timing unchanged.
- Reset mid-operation: assert reset_n=0 after 1 CALC cycle → C_mat = 0, busy = 0, valid = 0 immediately (asynchronous, without waiting for a clock edge); a subsequent start computes a correct result.
- SIGNED=1: A and B all -128 → every C element = 49152. A = identity, B all -1 → every element = -1 (0x3FFFF).
- N=4, W=4: A = B = all 15 → every element = 900; valid rises 4 cycles after the start edge.

Source files
------------

// File: rtl/mmult_seq.sv
// Sequential N x N matrix multiplier: C = A*B or C += A*B, one row of C per clock.
// Operands are captured on an accepted start; C_mat is meaningful only while valid is high.
module mmult_seq #(
  parameter int unsigned N      = 3,
  parameter int unsigned W      = 8,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned CW     = 2*W + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  acc_en,
  input  logic [0:N*N*W-1]      A_mat,
  input  logic [0:N*N*W-1]      B_mat,
  output logic                  busy,
  output logic                  valid,
  output logic [0:N*N*CW-1]     C_mat
);

  localparam int unsigned RW = $clog2(N);
  localparam int unsigned EW = CW - 2*W;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic            load, calc, last;
  logic            acc_q;
  logic [RW-1:0]   row_q;
  logic [W-1:0]    a_in [N][N];
  logic [W-1:0]    b_in [N][N];
  logic [W-1:0]    a_q  [N][N];
  logic [W-1:0]    b_q  [N][N];
  logic [CW-1:0]   c_q  [N][N];
  logic [CW-1:0]   row_sum [N];

  // W x W product, sign- or zero-extended to the result width
  function automatic logic [CW-1:0] mul_ext(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    if (SIGNED) p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
    else        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return SIGNED ? {{EW{p[2*W-1]}}, p} : {{EW{1'b0}}, p};
  endfunction

  // Unpack row-major operand buses into element arrays
  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a_in[r][c] = A_mat[(r*N+c)*W +: W];
        b_in[r][c] = B_mat[(r*N+c)*W +: W];
      end
    end
  end

  always_comb begin
    C_mat = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        C_mat[(r*N+c)*CW +: CW] = c_q[r][c];
      end
    end
  end

  // Dot products of the current A row with every B column
  always_comb begin
    for (int j = 0; j < N; j++) begin
      row_sum[j] = '0;
      for (int k = 0; k < N; k++) begin
        row_sum[j] = row_sum[j] + mul_ext(a_q[row_q][k], b_q[k][j]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    calc    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        calc = 1'b1;
        last = (row_q == RW'(N-1));
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      c_q   <= '{default: '0};
      acc_q <= 1'b0;
      row_q <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_en;
      row_q <= '0;
      busy  <= 1'b1;
      valid <= 1'b0;
      if (!acc_en) c_q <= '{default: '0};
    end else if (calc) begin
      for (int j = 0; j < N; j++) begin
        c_q[row_q][j] <= (acc_q ? c_q[row_q][j] : CW'(0)) + row_sum[j];
      end
      row_q <= last ? '0 : row_q + RW'(1);
      if (last) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmult_seq.sv
// Bench for mmult_seq: default, signed and 4x4/4-bit instances checked against a
// behavioural matrix model through per-instance expected-result queues.
module tb_mmult_seq;

  logic clk = 1'b0;
  logic reset_n;
  logic start0, acc0, start1, acc1, start2, acc2;
  logic [0:71]  a0, b0, a1, b1;
  logic [0:63]  a2, b2;
  logic busy0, valid0, busy1, valid1, busy2, valid2;
  logic [0:161] c0, c1;
  logic [0:159] c2;

  logic [0:161] q0[$];
  logic [0:161] q1[$];
  logic [0:159] q2[$];
  int checks = 0;
  int errors = 0;
  bit pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;

  always #5 clk = ~clk;

  mmult_seq #(.N(3), .W(8), .SIGNED(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .acc_en(acc0),
    .A_mat(a0), .B_mat(b0), .busy(busy0), .valid(valid0), .C_mat(c0));
  mmult_seq #(.N(3), .W(8), .SIGNED(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .acc_en(acc1),
    .A_mat(a1), .B_mat(b1), .busy(busy1), .valid(valid1), .C_mat(c1));
  mmult_seq #(.N(4), .W(4), .SIGNED(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .acc_en(acc2),
    .A_mat(a2), .B_mat(b2), .busy(busy2), .valid(valid2), .C_mat(c2));

  // Reference model for the 3x3, 8-bit, 18-bit-result instances
  function automatic logic [0:161] model3(input bit sgn, input logic [0:71] a, input logic [0:71] b,
                                          input bit acc, input logic [0:161] cold);
    logic [0:161] res;
    logic [17:0]  s;
    logic [7:0]   ea, eb;
    longint       x, y;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = acc ? cold[(i*3+j)*18 +: 18] : 18'd0;
        for (int k = 0; k < 3; k++) begin
          ea = a[(i*3+k)*8 +: 8];
          eb = b[(k*3+j)*8 +: 8];
          if (sgn) begin
            x = longint'($signed(ea));
            y = longint'($signed(eb));
          end else begin
            x = longint'(ea);
            y = longint'(eb);
          end
          s = s + 18'(x * y);
        end
        res[(i*3+j)*18 +: 18] = s;
      end
    end
    return res;
  endfunction

  function automatic logic [0:159] model4(input logic [0:63] a, input logic [0:63] b);
    logic [0:159] res;
    logic [9:0]   s;
    longint       x, y;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 10'd0;
        for (int k = 0; k < 4; k++) begin
          x = longint'(a[(i*4+k)*4 +: 4]);
          y = longint'(b[(k*4+j)*4 +: 4]);
          s = s + 10'(x * y);
        end
        res[(i*4+j)*10 +: 10] = s;
      end
    end
    return res;
  endfunction

  function automatic logic [0:71] seq9();
    logic [0:71] v;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(i + 1);
    return v;
  endfunction

  function automatic logic [0:71] id3();
    logic [0:71] v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) v[(r*3+c)*8 +: 8] = (r == c) ? 8'd1 : 8'd0;
    return v;
  endfunction

  function automatic logic [0:71] fill3(input logic [7:0] e);
    logic [0:71] v;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = e;
    return v;
  endfunction

  function automatic bit vsel(input int d);
    return (d == 0) ? valid0 : (d == 1) ? valid1 : valid2;
  endfunction

  function automatic bit bsel(input int d);
    return (d == 0) ? busy0 : (d == 1) ? busy1 : busy2;
  endfunction

  // One start pulse on instance d; reports edges until valid and cycles with busy high
  task automatic do_op(input int d, input bit acc, output int lat, output int bcnt);
    @(negedge clk);
    case (d)
      0: begin start0 = 1'b1; acc0 = acc; end
      1: begin start1 = 1'b1; acc1 = acc; end
      default: begin start2 = 1'b1; acc2 = acc; end
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!vsel(d) && lat < 50) begin
      if (bsel(d)) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Scoreboard: each rising valid pops one expected result
  always @(negedge clk) begin
    if (valid0 && !pv0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++; $display("FAIL sb0: unexpected valid, C=%h", c0);
      end else begin
        logic [0:161] e;
        e = q0.pop_front();
        if (c0 !== e) begin errors++; $display("FAIL sb0: C=%h expected %h", c0, e); end
      end
    end
    if (valid1 && !pv1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++; $display("FAIL sb1: unexpected valid, C=%h", c1);
      end else begin
        logic [0:161] e;
        e = q1.pop_front();
        if (c1 !== e) begin errors++; $display("FAIL sb1: C=%h expected %h", c1, e); end
      end
    end
    if (valid2 && !pv2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++; $display("FAIL sb2: unexpected valid, C=%h", c2);
      end else begin
        logic [0:159] e;
        e = q2.pop_front();
        if (c2 !== e) begin errors++; $display("FAIL sb2: C=%h expected %h", c2, e); end
      end
    end
    pv0 = valid0;
    pv1 = valid1;
    pv2 = valid2;
  end

  task automatic test_reset();
    reset_n = 1'b0;
    start0 = 1'b0; acc0 = 1'b0; start1 = 1'b0; acc1 = 1'b0; start2 = 1'b0; acc2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b want 0", valid0); end
    checks++; if (c0 !== '0) begin errors++; $display("FAIL reset_c0: got %h want 0", c0); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid2: got %b want 0", valid2); end
    checks++; if (c2 !== '0) begin errors++; $display("FAIL reset_c2: got %h want 0", c2); end
    reset_n = 1'b1;
  endtask

  task automatic test_identity();
    int lat, bc;
    bit ok;
    a0 = seq9();
    b0 = id3();
    q0.push_back(model3(1'b0, a0, b0, 1'b0, '0));
    do_op(0, 1'b0, lat, bc);
    checks++; if (lat != 3) begin errors++; $display("FAIL ident_latency: got %0d want 3", lat); end
    checks++; if (bc != 3) begin errors++; $display("FAIL ident_busy_cycles: got %0d want 3", bc); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ident_busy_done: got %b want 0", busy0); end
    ok = 1'b1;
    for (int i = 0; i < 9; i++) if (c0[i*18 +: 18] !== 18'(i + 1)) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL ident_values: got %h want elements 1..9", c0); end
  endtask

  task automatic test_max_acc();
    int lat, bc;
    logic [0:161] e1;
    a0 = fill3(8'hFF);
    b0 = fill3(8'hFF);
    e1 = model3(1'b0, a0, b0, 1'b0, '0);
    q0.push_back(e1);
    do_op(0, 1'b0, lat, bc);
    checks++; if (c0[8*18 +: 18] !== 18'd195075) begin errors++; $display("FAIL max_elem: got %0d want 195075", c0[8*18 +: 18]); end
    q0.push_back(model3(1'b0, a0, b0, 1'b1, e1));
    do_op(0, 1'b1, lat, bc);
    checks++; if (lat != 3) begin errors++; $display("FAIL acc_latency: got %0d want 3", lat); end
    checks++; if (c0[0 +: 18] !== 18'd128006) begin errors++; $display("FAIL acc_wrap: got %0d want 128006", c0[0 +: 18]); end
  endtask

  task automatic test_ignored_start();
    int lat;
    a0 = seq9();
    b0 = id3();
    q0.push_back(model3(1'b0, a0, b0, 1'b0, '0));
    @(negedge clk);
    start0 = 1'b1; acc0 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      a0[i*8 +: 8] = 8'($urandom);
      b0[i*8 +: 8] = 8'($urandom);
    end
    lat = 0;
    while (!valid0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    start0 = 1'b0;
    checks++; if (lat != 3) begin errors++; $display("FAIL ignore_latency: got %0d want 3", lat); end
    repeat (2) @(negedge clk);
    checks++; if (valid0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++; $display("FAIL ignore_hold: valid=%b busy=%b want 1/0", valid0, busy0);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    a0 = seq9();
    b0 = id3();
    @(negedge clk);
    start0 = 1'b1; acc0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    checks++; if (c0[0 +: 18] !== 18'd1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL mid_row0: c00=%0d busy=%b want 1/1", c0[0 +: 18], busy0);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0 || valid0 !== 1'b0 || c0 !== '0) begin
      errors++; $display("FAIL mid_async_reset: busy=%b valid=%b C=%h want 0/0/0", busy0, valid0, c0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    q0.push_back(model3(1'b0, a0, b0, 1'b0, '0));
    do_op(0, 1'b0, lat, bc);
    checks++; if (lat != 3) begin errors++; $display("FAIL mid_restart_latency: got %0d want 3", lat); end
  endtask

  task automatic test_signed();
    int lat, bc;
    a1 = fill3(8'h80);
    b1 = fill3(8'h80);
    q1.push_back(model3(1'b1, a1, b1, 1'b0, '0));
    do_op(1, 1'b0, lat, bc);
    checks++; if (c1[4*18 +: 18] !== 18'd49152) begin errors++; $display("FAIL signed_min: got %0d want 49152", c1[4*18 +: 18]); end
    a1 = id3();
    b1 = fill3(8'hFF);
    q1.push_back(model3(1'b1, a1, b1, 1'b0, '0));
    do_op(1, 1'b0, lat, bc);
    checks++; if (c1[2*18 +: 18] !== 18'h3FFFF) begin errors++; $display("FAIL signed_neg1: got %h want 3ffff", c1[2*18 +: 18]); end
  endtask

  task automatic test_n4();
    int lat, bc;
    for (int i = 0; i < 16; i++) begin
      a2[i*4 +: 4] = 4'hF;
      b2[i*4 +: 4] = 4'hF;
    end
    q2.push_back(model4(a2, b2));
    do_op(2, 1'b0, lat, bc);
    checks++; if (lat != 4) begin errors++; $display("FAIL n4_latency: got %0d want 4", lat); end
    checks++; if (bc != 4) begin errors++; $display("FAIL n4_busy_cycles: got %0d want 4", bc); end
    checks++; if (c2[15*10 +: 10] !== 10'd900) begin errors++; $display("FAIL n4_elem: got %0d want 900", c2[15*10 +: 10]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_max_acc();
    test_ignored_start();
    test_reset_mid();
    test_signed();
    test_n4();
    repeat (3) @(negedge clk);
    checks++; if (q0.size() != 0) begin errors++; $display("FAIL sb0_drain: %0d results missing", q0.size()); end
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL sb1_drain: %0d results missing", q1.size()); end
    checks++; if (q2.size() != 0) begin errors++; $display("FAIL sb2_drain: %0d results missing", q2.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
